// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state, owner and op encodings for the memory-port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/arb_rr_select.sv
// arb_rr_select: combinational winner pick; in i_req/d_req/prio (0=D first), out grant_valid/grant_id
module arb_rr_select
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic prio,
  output logic grant_valid,
  output logic grant_id
);
  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = (i_req & d_req) ? (prio ? OWN_I : OWN_D) : (d_req ? OWN_D : OWN_I);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: I/D cache to single memory port arbiter; in i_*/d_* requests, mem_rdata/mem_ready; out registered mem_* strobes, *_ready pulses, *_rdata
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter bit WB_LOCK = 1'b1
) (
  input  logic              clk,
  input  logic              cache_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  state_t state;
  logic   prio, owner, op;
  logic   i_req, d_req, grant_valid, grant_id, win_wr;
  assign i_req  = i_read ^ i_write;
  assign d_req  = d_read ^ d_write;
  assign win_wr = (grant_id == OWN_D) ? d_write : i_write;
  arb_rr_select u_sel (
    .i_req      (i_req),
    .d_req      (d_req),
    .prio       (prio),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );
  always_ff @(posedge clk) begin
    if (cache_reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      owner     <= OWN_I;
      op        <= OP_RD;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          owner     <= grant_id;
          op        <= win_wr ? OP_WR : OP_RD;
          mem_read  <= ~win_wr;
          mem_write <= win_wr;
          mem_addr  <= (grant_id == OWN_D) ? d_addr : i_addr;
          mem_wdata <= (grant_id == OWN_D) ? d_wdata : i_wdata;
          state     <= BUSY;
        end
        BUSY: if (mem_ready) begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          i_ready   <= (owner == OWN_I);
          d_ready   <= (owner == OWN_D);
          if (op == OP_RD && owner == OWN_I) i_rdata <= mem_rdata;
          if (op == OP_RD && owner == OWN_D) d_rdata <= mem_rdata;
          state     <= DONE;
        end
        DONE: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          // a locked D write-back keeps D first so its refill follows directly
          prio    <= (owner == OWN_D) && !(WB_LOCK && op == OP_WR);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with WB_LOCK=1 and WB_LOCK=0 instances
module tb_mem_arbiter;
  typedef struct packed {logic wr; logic [27:0] addr; logic [127:0] data;} txn_t;
  typedef struct packed {logic bh; logic wr; logic [27:0] addr; logic [127:0] data;} cmd_t;
  logic clk = 0;
  logic cache_reset = 1;
  logic i_read = 0, i_write = 0, d_read = 0, d_write = 0;
  logic [27:0] i_addr = 0, d_addr = 0;
  logic [127:0] i_wdata = 0, d_wdata = 0;
  logic [127:0] mem_rdata = 0;
  logic mem_ready = 0;
  logic a_i_ready, a_d_ready, a_mem_read, a_mem_write, b_i_ready, b_d_ready, b_mem_read, b_mem_write;
  logic [127:0] a_i_rdata, a_d_rdata, a_mem_wdata, b_i_rdata, b_d_rdata, b_mem_wdata;
  logic [27:0] a_mem_addr, b_mem_addr;
  logic sel = 0;
  logic m_read, m_write, ir, dr;
  logic [27:0] m_addr;
  logic [127:0] m_wdata, irdata, drdata;
  int tests = 0, fails = 0;
  int cyc = 0, cnt = 0, lat = 0, stray_at = -1;
  int i_pulses = 0, d_pulses = 0, i_lat = 0, i_t0 = 0;
  bit i_act = 0, d_act = 0;
  cmd_t iq[$], dq[$];
  txn_t exp_q[$];
  logic [127:0] i_done[$], d_done[$];

  always #5 clk = ~clk;

  mem_arbiter #(.WB_LOCK(1'b1)) dut_a (
    .clk(clk), .cache_reset(cache_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata), .i_ready(a_i_ready), .i_rdata(a_i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(a_d_ready), .d_rdata(a_d_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  mem_arbiter #(.WB_LOCK(1'b0)) dut_b (
    .clk(clk), .cache_reset(cache_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata), .i_ready(b_i_ready), .i_rdata(b_i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(b_d_ready), .d_rdata(b_d_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  assign m_read  = sel ? b_mem_read  : a_mem_read;
  assign m_write = sel ? b_mem_write : a_mem_write;
  assign m_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign m_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign ir      = sel ? b_i_ready   : a_i_ready;
  assign dr      = sel ? b_d_ready   : a_d_ready;
  assign irdata  = sel ? b_i_rdata   : a_i_rdata;
  assign drdata  = sel ? b_d_rdata   : a_d_rdata;

  function automatic logic [127:0] data_of(input logic [27:0] a);
    return (a == 28'h10) ? {16{8'hA5}} : {4{{4'h0, a}}};
  endfunction

  // memory model and in-order scoreboard
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_ready <= (cyc == stray_at);
    if (cache_reset) cnt <= 0;
    else if ((m_read || m_write) && !mem_ready) begin
      if (cnt == lat) begin
        txn_t o, e;
        o = '{m_write, m_addr, m_wdata};
        mem_ready <= 1'b1;
        cnt <= 0;
        mem_rdata <= data_of(m_addr);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL order: unexpected wr=%0b addr=%h wdata=%h", o.wr, o.addr, o.data);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            fails++;
            $display("FAIL order: got wr=%0b addr=%h wdata=%h, expected wr=%0b addr=%h wdata=%h",
                     o.wr, o.addr, o.data, e.wr, e.addr, e.data);
          end
        end
      end else cnt <= cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!cache_reset) begin
      tests++;
      if ((m_read && m_write) !== 1'b0) begin
        fails++;
        $display("FAIL strobes: mem_read=%0b mem_write=%0b, required not both 1", m_read, m_write);
      end
    end
  end

  always @(posedge clk) begin : i_side
    bit rs;
    cmd_t c;
    rs = cache_reset;
    #1;
    if (rs) begin
      i_act = 0; i_read = 0; i_write = 0;
    end else begin
      if (ir) i_pulses++;
      if (i_act && ir) begin
        i_done.push_back(irdata); i_lat = cyc - i_t0; i_act = 0; i_read = 0; i_write = 0;
      end
      if (!i_act && iq.size() > 0) begin
        c = iq.pop_front();
        i_act = 1; i_t0 = cyc;
        i_read = c.bh | ~c.wr; i_write = c.bh | c.wr; i_addr = c.addr; i_wdata = c.data;
      end
    end
  end

  always @(posedge clk) begin : d_side
    bit rs;
    cmd_t c;
    rs = cache_reset;
    #1;
    if (rs) begin
      d_act = 0; d_read = 0; d_write = 0;
    end else begin
      if (dr) d_pulses++;
      if (d_act && dr) begin
        d_done.push_back(drdata); d_act = 0; d_read = 0; d_write = 0;
      end
      if (!d_act && dq.size() > 0) begin
        c = dq.pop_front();
        d_act = 1;
        d_read = c.bh | ~c.wr; d_write = c.bh | c.wr; d_addr = c.addr; d_wdata = c.data;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 cache_reset = 1;
    @(posedge clk); #1 cache_reset = 0;
    exp_q.delete(); i_done.delete(); d_done.delete();
    i_pulses = 0; d_pulses = 0;
  endtask

  task automatic push_i(input logic wr, input logic [27:0] a, input logic [127:0] w);
    iq.push_back('{1'b0, wr, a, w});
  endtask

  task automatic push_d(input logic wr, input logic [27:0] a, input logic [127:0] w);
    dq.push_back('{1'b0, wr, a, w});
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0 || i_act || d_act || exp_q.size() != 0) && n < 400) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #2;
    tests++;
    if (n >= 400) begin
      fails++;
      $display("FAIL %s: timeout after %0d cycles, pending exp=%0d", nm, n, exp_q.size());
    end
  endtask

  task automatic test_reset();
    sel = 0;
    @(posedge clk); #1 cache_reset = 0;
    #1;
    tests++;
    if ({a_mem_read, a_mem_write, a_i_ready, a_d_ready, b_mem_read, b_mem_write, b_i_ready, b_d_ready} !== 8'h0) begin
      fails++; $display("FAIL reset_strobes: got %b, required 0", {a_mem_read, a_mem_write, a_i_ready, a_d_ready});
    end
    tests++;
    if ({a_mem_addr, a_mem_wdata} !== '0) begin
      fails++; $display("FAIL reset_mem_regs: addr=%h wdata=%h, required 0", a_mem_addr, a_mem_wdata);
    end
    tests++;
    if ({a_i_rdata, a_d_rdata} !== '0) begin
      fails++; $display("FAIL reset_rdata: i=%h d=%h, required 0", a_i_rdata, a_d_rdata);
    end
  endtask

  task automatic test_single_read();
    sel = 0; lat = 2;
    do_reset();
    exp_q.push_back('{1'b0, 28'h0000010, 128'h0});
    push_i(1'b0, 28'h0000010, 128'h0);
    wait_done("single_read");
    tests++;
    if (i_pulses !== 1) begin fails++; $display("FAIL single_i_pulses: got %0d, required 1", i_pulses); end
    tests++;
    if (d_pulses !== 0) begin fails++; $display("FAIL single_d_pulses: got %0d, required 0", d_pulses); end
    tests++;
    if (a_i_rdata !== {16{8'hA5}}) begin fails++; $display("FAIL single_rdata: got %h, required %h", a_i_rdata, {16{8'hA5}}); end
    tests++;
    if (i_lat !== 5) begin fails++; $display("FAIL single_latency: got %0d, required 5", i_lat); end
  endtask

  task automatic test_alternation();
    sel = 0; lat = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{1'b0, 28'h30 + 28'(k), 128'h0});
      exp_q.push_back('{1'b0, 28'h20 + 28'(k), 128'h0});
      push_d(1'b0, 28'h30 + 28'(k), 128'h0);
      push_i(1'b0, 28'h20 + 28'(k), 128'h0);
    end
    wait_done("alternation");
    tests++;
    if (i_pulses !== 3 || d_pulses !== 3) begin
      fails++; $display("FAIL alt_pulses: got i=%0d d=%0d, required 3 and 3", i_pulses, d_pulses);
    end
    tests++;
    if (a_d_rdata !== data_of(28'h32)) begin fails++; $display("FAIL alt_d_rdata: got %h, required %h", a_d_rdata, data_of(28'h32)); end
    tests++;
    if (a_i_rdata !== data_of(28'h22)) begin fails++; $display("FAIL alt_i_rdata: got %h, required %h", a_i_rdata, data_of(28'h22)); end
  endtask

  task automatic test_back_to_back(input logic s);
    logic [127:0] v;
    sel = s; lat = 1;
    do_reset();
    exp_q.push_back('{1'b1, 28'h100, 128'h1234});
    if (s) begin
      exp_q.push_back('{1'b0, 28'h300, 128'h0});
      exp_q.push_back('{1'b0, 28'h200, 128'h0});
    end else begin
      exp_q.push_back('{1'b0, 28'h200, 128'h0});
      exp_q.push_back('{1'b0, 28'h300, 128'h0});
    end
    push_i(1'b0, 28'h300, 128'h0);
    push_d(1'b1, 28'h100, 128'h1234);
    push_d(1'b0, 28'h200, 128'h0);
    wait_done(s ? "b2b_nolock" : "b2b_lock");
    tests++;
    if (d_done.size() != 2 || i_done.size() != 1) begin
      fails++; $display("FAIL b2b_completions: got d=%0d i=%0d, required 2 and 1", d_done.size(), i_done.size());
    end else begin
      v = d_done.pop_front();
      tests++;
      if (v !== 128'h0) begin fails++; $display("FAIL b2b_write_rdata: got %h, required 0", v); end
      v = d_done.pop_front();
      tests++;
      if (v !== data_of(28'h200)) begin fails++; $display("FAIL b2b_d_rdata: got %h, required %h", v, data_of(28'h200)); end
      v = i_done.pop_front();
      tests++;
      if (v !== data_of(28'h300)) begin fails++; $display("FAIL b2b_i_rdata: got %h, required %h", v, data_of(28'h300)); end
    end
  endtask

  task automatic test_both_high();
    bit bad = 0;
    sel = 0; lat = 0;
    do_reset();
    iq.push_back('{1'b1, 1'b0, 28'h44, 128'h0});
    repeat (11) begin
      @(posedge clk); #2;
      if (m_read || m_write || ir || dr) bad = 1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL both_high_strobes: activity seen, required none"); end
    tests++;
    if (i_pulses + d_pulses !== 0) begin fails++; $display("FAIL both_high_pulses: got %0d, required 0", i_pulses + d_pulses); end
    do_reset();
  endtask

  task automatic test_reset_busy();
    int n = 0;
    sel = 0; lat = 8;
    do_reset();
    push_i(1'b0, 28'h40, 128'h0);
    while (!m_read && n < 20) begin @(posedge clk); #2; n++; end
    tests++;
    if (!m_read) begin fails++; $display("FAIL rst_busy_start: mem_read=%0b, required 1", m_read); end
    @(posedge clk); #1 cache_reset = 1;
    stray_at = cyc + 3;
    @(posedge clk); #1 cache_reset = 0;
    tests++;
    if ({a_mem_read, a_mem_write, a_i_ready, a_d_ready, a_mem_addr, a_mem_wdata, a_i_rdata, a_d_rdata} !== '0) begin
      fails++; $display("FAIL rst_busy_outputs: read=%0b write=%0b addr=%h, required all 0", a_mem_read, a_mem_write, a_mem_addr);
    end
    repeat (8) @(posedge clk);
    #2;
    tests++;
    if (i_pulses + d_pulses !== 0) begin fails++; $display("FAIL rst_busy_pulses: got %0d, required 0", i_pulses + d_pulses); end
    stray_at = -1; lat = 1;
    exp_q.push_back('{1'b0, 28'h50, 128'h0});
    push_i(1'b0, 28'h50, 128'h0);
    wait_done("rst_busy_fresh");
    tests++;
    if (i_pulses !== 1 || a_i_rdata !== data_of(28'h50)) begin
      fails++; $display("FAIL rst_busy_fresh: pulses=%0d rdata=%h, required 1 and %h", i_pulses, a_i_rdata, data_of(28'h50));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_single_read();
    test_alternation();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_both_high();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
